// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } serial_sub_state_t;

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor, one bit per clock, start/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
//
// state | meaning
// IDLE  | waiting for start; last result held on diff/borrow
// RUN   | one operand bit pair processed per cycle, WIDTH cycles
// DONE  | one-cycle done pulse; start here begins the next op back-to-back
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    serial_sub_state_t state_q;
    serial_sub_state_t state_d;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] shadow;
    logic [WIDTH-1:0] shadow_full;
    logic [CW-1:0]    count;
    logic             bin;
    logic             d_bit;
    logic             bout_bit;
    logic             last_bit;
    logic             accept;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    full_subtractor_bit u_fsb (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (bin),
        .d    (d_bit),
        .bout (bout_bit)
    );

    // The final bit completes the result without an extra shift cycle.
    assign shadow_full = {d_bit, shadow};
    assign last_bit    = (count == LAST);
    assign accept      = start && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            shadow <= '0;
            count  <= '0;
            bin    <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            bin    <= 1'b0;
            count  <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
`endif
        end else if (state_q == RUN) begin
            a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
            bin    <= bout_bit;
            shadow <= shadow_full[WIDTH-1:1];
            if (last_bit) begin
                diff   <= shadow_full;
                borrow <= bout_bit;
`ifdef SERIAL_SUB_OVF_EN
                ovf    <= (a_msb != b_msb) && (d_bit != a_msb);
`endif
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule
